// File: rtl/mem_loader.sv
// Serial-link bus initiator: parses write/read commands from the Rx byte stream,
// drives the memory port and streams read data back over Tx while holding the CPU.
module mem_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned READ_LATENCY   = 1
) (
    input  logic        i_CLK,
    input  logic        i_RESET_n,
    input  logic [7:0]  i_Rx_Byte,
    input  logic        i_Rx_Valid,
    output logic [7:0]  o_Tx_Byte,
    output logic        o_Tx_Valid,
    input  logic        i_Tx_Ready,
    output logic [15:0] o_Mem_Address,
    output logic [15:0] o_Mem_Data,
    output logic        o_Mem_Write_EN,
    input  logic [15:0] i_Mem_Data,
    output logic        o_Busy,
    output logic        o_Error
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;
    localparam int unsigned TW = 32;
    localparam int unsigned LW = 2;

    localparam logic [BW-1:0] CMD_WRITE = 8'h57;
    localparam logic [BW-1:0] CMD_READ  = 8'h52;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L,
        S_DATA_H, S_DATA_L, S_WR, S_RD_WAIT, S_TX_H, S_TX_L
    } state_t;

    state_t          state, state_nxt;
    logic            mode_wr, mode_wr_nxt;
    logic [AW-1:0]   addr, addr_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic [BW-1:0]   hi_byte, hi_byte_nxt;
    logic [BW-1:0]   rd_lo, rd_lo_nxt;
    logic [BW-1:0]   tx_byte, tx_byte_nxt;
    logic            tx_valid, tx_valid_nxt;
    logic [DW-1:0]   mem_data, mem_data_nxt;
    logic            mem_we, mem_we_nxt;
    logic            busy, busy_nxt;
    logic            error, error_nxt;
    logic [LW-1:0]   lat_cnt, lat_cnt_nxt;
    logic [TW-1:0]   idle_cnt, idle_cnt_nxt;
    logic            timed;

    // State and datapath registers
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state    <= S_IDLE;
            mode_wr  <= 1'b0;
            addr     <= '0;
            cnt      <= '0;
            hi_byte  <= '0;
            rd_lo    <= '0;
            tx_byte  <= '0;
            tx_valid <= 1'b0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b0;
            lat_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            mode_wr  <= mode_wr_nxt;
            addr     <= addr_nxt;
            cnt      <= cnt_nxt;
            hi_byte  <= hi_byte_nxt;
            rd_lo    <= rd_lo_nxt;
            tx_byte  <= tx_byte_nxt;
            tx_valid <= tx_valid_nxt;
            mem_data <= mem_data_nxt;
            mem_we   <= mem_we_nxt;
            busy     <= busy_nxt;
            error    <= error_nxt;
            lat_cnt  <= lat_cnt_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        mode_wr_nxt  = mode_wr;
        addr_nxt     = addr;
        cnt_nxt      = cnt;
        hi_byte_nxt  = hi_byte;
        rd_lo_nxt    = rd_lo;
        tx_byte_nxt  = tx_byte;
        tx_valid_nxt = tx_valid;
        mem_data_nxt = mem_data;
        mem_we_nxt   = 1'b0;
        busy_nxt     = busy;
        error_nxt    = error;
        lat_cnt_nxt  = lat_cnt;
        idle_cnt_nxt = '0;
        timed        = (state == S_ADDR_H) || (state == S_ADDR_L) || (state == S_CNT_H) ||
                       (state == S_CNT_L)  || (state == S_DATA_H) || (state == S_DATA_L);

        case (state)
            S_IDLE: begin
                if (i_Rx_Valid) begin
                    if (i_Rx_Byte == CMD_WRITE || i_Rx_Byte == CMD_READ) begin
                        mode_wr_nxt = (i_Rx_Byte == CMD_WRITE);
                        error_nxt   = 1'b0;
                        busy_nxt    = 1'b1;
                        state_nxt   = S_ADDR_H;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
            end
            S_ADDR_H: if (i_Rx_Valid) begin
                addr_nxt[15:8] = i_Rx_Byte;
                state_nxt      = S_ADDR_L;
            end
            S_ADDR_L: if (i_Rx_Valid) begin
                addr_nxt[7:0] = i_Rx_Byte;
                state_nxt     = S_CNT_H;
            end
            S_CNT_H: if (i_Rx_Valid) begin
                cnt_nxt[15:8] = i_Rx_Byte;
                state_nxt     = S_CNT_L;
            end
            S_CNT_L: if (i_Rx_Valid) begin
                cnt_nxt = {cnt[15:8], i_Rx_Byte};
                if ({cnt[15:8], i_Rx_Byte} == '0) begin
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else if (mode_wr) begin
                    state_nxt = S_DATA_H;
                end else begin
                    lat_cnt_nxt = '0;
                    state_nxt   = S_RD_WAIT;
                end
            end
            S_DATA_H: if (i_Rx_Valid) begin
                hi_byte_nxt = i_Rx_Byte;
                state_nxt   = S_DATA_L;
            end
            S_DATA_L: if (i_Rx_Valid) begin
                mem_we_nxt   = 1'b1;
                mem_data_nxt = {hi_byte, i_Rx_Byte};
                state_nxt    = S_WR;
            end
            S_WR: begin
                addr_nxt = addr + AW'(1);
                cnt_nxt  = cnt - AW'(1);
                if (cnt == AW'(1)) begin
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_DATA_H;
                end
            end
            S_RD_WAIT: begin
                if (lat_cnt == LW'(READ_LATENCY - 1)) begin
                    rd_lo_nxt    = i_Mem_Data[7:0];
                    tx_byte_nxt  = i_Mem_Data[15:8];
                    tx_valid_nxt = 1'b1;
                    state_nxt    = S_TX_H;
                end else begin
                    lat_cnt_nxt = lat_cnt + LW'(1);
                end
            end
            S_TX_H: if (i_Tx_Ready) begin
                tx_byte_nxt = rd_lo;
                state_nxt   = S_TX_L;
            end
            S_TX_L: if (i_Tx_Ready) begin
                tx_valid_nxt = 1'b0;
                addr_nxt     = addr + AW'(1);
                cnt_nxt      = cnt - AW'(1);
                if (cnt == AW'(1)) begin
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    lat_cnt_nxt = '0;
                    state_nxt   = S_RD_WAIT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Bytes arriving while the block cannot take them are dropped and flagged
        if (i_Rx_Valid && (state == S_WR || state == S_RD_WAIT ||
                           state == S_TX_H || state == S_TX_L)) begin
            error_nxt = 1'b1;
        end

        if (timed && !i_Rx_Valid && TIMEOUT_CYCLES != 0 &&
            idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            error_nxt = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
        end

        if (timed && !i_Rx_Valid && state_nxt == state) begin
            idle_cnt_nxt = idle_cnt + TW'(1);
        end
    end

    assign o_Tx_Byte      = tx_byte;
    assign o_Tx_Valid     = tx_valid;
    assign o_Mem_Address  = addr;
    assign o_Mem_Data     = mem_data;
    assign o_Mem_Write_EN = mem_we;
    assign o_Busy         = busy;
    assign o_Error        = error;

endmodule

// File: doc/mem_loader.md
# mem_loader

Byte-stream bus initiator that lets a host load and read back the 16-bit memory space over the serial link while the CPU is held. Sits between the UART receive/transmit byte interfaces and the Memory block's address/data/write-enable port, muxed in front of the CPU's memory port while `o_Busy` is high. Implements a small binary command protocol: write N words from an address, or read N words from an address and stream them back.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: idle cycles allowed mid-command before abort; 0 disables the timeout.
- `READ_LATENCY`, default 1: cycles from `o_Mem_Address` stable to `i_Mem_Data` valid; range 1–3.
- `i_CLK` in 1: system clock; all logic on the rising edge.
- `i_RESET_n` in 1: reset, asynchronous, active-low.
- `i_Rx_Byte` in 8: received byte.
- `i_Rx_Valid` in 1: one-cycle strobe, `i_Rx_Byte` valid; cannot be stalled.
- `o_Tx_Byte` out 8: byte to transmit.
- `o_Tx_Valid` out 1: `o_Tx_Byte` valid.
- `i_Tx_Ready` in 1: transmitter accepts the byte when `o_Tx_Valid` and `i_Tx_Ready` are both high at a rising edge.
- `o_Mem_Address` out 16: memory address.
- `o_Mem_Data` out 16: write data.
- `o_Mem_Write_EN` out 1: one-cycle write strobe.
- `i_Mem_Data` in 16: read data from Memory.
- `o_Busy` out 1: high in every state except IDLE; holds the CPU.
- `o_Error` out 1: sticky protocol error flag.

## Operation
- **Protocol:** all multi-byte fields are big-endian.
  - Write: `0x57`, ADDR_H, ADDR_L, CNT_H, CNT_L, then CNT words as hi,lo byte pairs.
  - Read: `0x52`, ADDR_H, ADDR_L, CNT_H, CNT_L; the block replies with CNT words as hi,lo byte pairs.
- **Command parsing:**
  - States: IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, WR, RD_WAIT, TX_H, TX_L.
  - IDLE, byte `0x57` or `0x52`: latch the mode, clear `o_Error`, go to ADDR_H.
  - IDLE, any other byte: set `o_Error`, stay in IDLE.
  - ADDR_H → ADDR_L → CNT_H → CNT_L: each state latches its byte on `i_Rx_Valid`.
  - After CNT_L:
    - CNT = 0: go to IDLE with no memory access and no Tx.
    - Write mode: go to DATA_H.
    - Read mode: go to RD_WAIT.
- **Write path:**
  - DATA_H latches the high byte.
  - DATA_L: on a byte, go to WR.
  - WR lasts one cycle, with `o_Mem_Write_EN`=1, `o_Mem_Data`={hi,lo}, and `o_Mem_Address`=current address.
  - Leaving WR: address+1, count−1; go to IDLE if count reaches 0, else DATA_H.
- **Read path:**
  - RD_WAIT holds the address for `READ_LATENCY` cycles, then captures `i_Mem_Data` into the word register.
  - TX_H presents the high byte; TX_L presents the low byte.
  - Each byte holds `o_Tx_Valid`=1 with `o_Tx_Byte` stable until the handshake.
  - After the TX_L handshake: address+1, count−1; go to IDLE if count reaches 0, else RD_WAIT.
- **Address arithmetic:** 16-bit with wrap, 0xFFFF+1 = 0x0000. No range checking; Memory decode ignores unmapped writes.
- **Rx byte during WR, RD_WAIT, TX_H or TX_L:** the byte is dropped and `o_Error` is set; the operation continues.
- **Timeout:** an idle counter is cleared on every `i_Rx_Valid` and on entering each state. It runs only in ADDR_H through DATA_L. Reaching `TIMEOUT_CYCLES` sets `o_Error` and returns to IDLE. No partial word is written.
- **Reset:** reset mid-operation aborts immediately; no write strobe is issued.

## Timing
- **Reset values:** state IDLE; all of these are 0: `o_Tx_Byte`, `o_Tx_Valid`, `o_Mem_Address`, `o_Mem_Data`, `o_Mem_Write_EN`, `o_Busy`, `o_Error`.
- All outputs are registered.
- **`o_Busy`:** rises the cycle after the command byte is accepted; falls the cycle after the final WR, after the final TX_L handshake, on abort, or after CNT_L with CNT = 0.
- **Write latency:** last data byte sampled at edge n → `o_Mem_Write_EN` high for exactly cycle n+1 → incremented address visible from cycle n+2.
- **Read latency:** address valid at cycle k → data captured at the end of cycle k+`READ_LATENCY`−1 → `o_Tx_Valid` high from cycle k+`READ_LATENCY`.
- **Tx stall:** `i_Tx_Ready` held low stalls indefinitely; the timeout does not apply in TX states.
- Maximum write throughput is one word per two received bytes; the WR state costs no extra Rx capacity.

## Test plan
- **Write then read:** reset; send 57 00 10 00 02 12 34 AB CD → writes 0x1234@0x0010 and 0xABCD@0x0011, each strobe exactly 1 cycle. Then send 52 00 10 00 02 → Tx bytes 12 34 AB CD, `o_Busy` low afterward.
- **Zero count:** send 57 00 00 00 00 → no `o_Mem_Write_EN` pulse, `o_Busy` back to 0, `o_Error`=0.
- **Wrap-around:** write 2 words at 0xFFFF → strobes at 0xFFFF then 0x0000. Read 2 from 0xFFFF → same data.
- **Bad command and recovery:** send 0x41 → `o_Error`=1, `o_Busy`=0. Next 0x52 command → `o_Error` clears.
- **Backpressure:** read 1 word with `i_Tx_Ready` low for 50 cycles → `o_Tx_Byte`/`o_Tx_Valid` stable throughout, each byte sent exactly once.
- **Timeout:** `TIMEOUT_CYCLES`=20; send 57 00 05 00 01 12 then silence → no write, `o_Error`=1, IDLE after 20 cycles. Also: reset asserted mid-DATA_L → all outputs 0 immediately.
